if_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC and selects the next PC: sequential, branch/jump redirect from D, exception entry, or eret return. It runs a request/ready handshake to a multi-cycle instruction memory and presents PC, instruction, valid and a pre-decoded nPC class to IF/ID. Misaligned or out-of-range fetches raise AdEL and do not access memory.

---
 rtl/if_fetch_stage_pkg.sv | 48 ++++
 rtl/if_fetch_stage_if.sv | 26 ++
 rtl/if_predecode.sv | 39 +++
 rtl/if_fetch_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared constants and types for the instruction-fetch
// stage and its downstream D-stage consumers.
//   - Reset / exception / instruction-memory address constants
//   - Fetch FSM state encoding
//   - nPC_sel control-flow class codes (also decoded by the D stage)
//   - MIPS opcode / funct constants used by the pre-decoder
//   - fetch_addr_ok(): alignment + range check for a fetch address
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
    localparam logic [31:0] IM_LAST_DEF   = 32'h0000_4FFC;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Control-flow class of the presented instruction
    localparam logic [2:0] NPC_SEQ  = 3'd0;
    localparam logic [2:0] NPC_BR   = 3'd1;
    localparam logic [2:0] NPC_J    = 3'd2;
    localparam logic [2:0] NPC_JR   = 3'd3;
    localparam logic [2:0] NPC_ERET = 3'd4;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

    // Legal fetch address: word aligned and inside [lo, hi]
    function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: request/ready handshake to the instruction memory.
//   imem_req   fetch -> mem   request pending (held until imem_ready)
//   imem_addr  fetch -> mem   word address, stable while imem_req is high
//   imem_ready mem -> fetch   imem_rdata valid this cycle
//   imem_rdata mem -> fetch   instruction word
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_predecode.sv
// if_predecode: purely combinational classifier of an instruction word into
// its control-flow class (nPC_sel code from if_fetch_stage_pkg).
//   instr_i    in  32  instruction word
//   npc_sel_o  out  3  NPC_SEQ / NPC_BR / NPC_J / NPC_JR / NPC_ERET
module if_predecode
    import if_fetch_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  npc_sel_o
);

    logic [5:0] op_s;
    logic [5:0] funct_s;

    assign op_s    = instr_i[31:26];
    assign funct_s = instr_i[5:0];

    // Classify opcode/funct; eret is matched on the full word first
    always_comb begin
        npc_sel_o = NPC_SEQ;
        if (instr_i == INSTR_ERET) begin
            npc_sel_o = NPC_ERET;
        end else begin
            case (op_s)
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: npc_sel_o = NPC_BR;
                OP_J, OP_JAL:                                npc_sel_o = NPC_J;
                OP_SPECIAL: begin
                    if ((funct_s == FN_JR) || (funct_s == FN_JALR)) begin
                        npc_sel_o = NPC_JR;
                    end else begin
                        npc_sel_o = NPC_SEQ;
                    end
                end
                default:                                     npc_sel_o = NPC_SEQ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC, picks the next PC (exception > eret > redirect > PC+4),
// fetches through a request/ready memory handshake and presents a registered
// PC / instruction / valid / nPC class / AdEL flag to IF/ID.
//   clk, reset (async, active low)
//   IR_en                      IF/ID load enable (0 = stall)
//   redirect_en, redirect_pc   control-flow redirect resolved in D
//   exc_req                    exception entry accepted by CP0
//   eret_req, EPC              eret return
//   imem                       instruction-memory handshake (master side)
//   PC_F, instr_F, instr_valid_F, nPC_sel_F, exc_adel_F  presented to IF/ID
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
    parameter logic [31:0] IM_LAST   = IM_LAST_DEF
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               IR_en,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_pc,
    input  logic               exc_req,
    input  logic               eret_req,
    input  logic [31:0]        EPC,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        PC_F,
    output logic [31:0]        instr_F,
    output logic               instr_valid_F,
    output logic [2:0]         nPC_sel_F,
    output logic               exc_adel_F
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [2:0]   npc_q, npc_d;
    logic         adel_q, adel_d;

    logic         flow_chg_s;
    logic [31:0]  flow_pc_s;
    logic         addr_ok_s;
    logic [31:0]  pc_plus4_s;
    logic [2:0]   pre_npc_s;

    if_predecode u_predecode (
        .instr_i   (imem.imem_rdata),
        .npc_sel_o (pre_npc_s)
    );

    assign flow_chg_s = exc_req | eret_req | redirect_en;
    assign addr_ok_s  = fetch_addr_ok(pc_q, IM_BASE, IM_LAST);
    assign pc_plus4_s = pc_q + 32'd4;

    // Redirect target by priority: exception, then eret, then D-stage redirect
    always_comb begin
        flow_pc_s = redirect_pc;
        if (exc_req) begin
            flow_pc_s = EXC_ENTRY;
        end else if (eret_req) begin
            flow_pc_s = EPC;
        end else begin
            flow_pc_s = redirect_pc;
        end
    end

    // State register: FSM state, PC, discard flag and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            pc_f_q    <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            valid_q   <= 1'b0;
            npc_q     <= NPC_SEQ;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            pc_f_q    <= pc_f_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            npc_q     <= npc_d;
            adel_q    <= adel_d;
        end
    end

    // Next-state logic: state, PC and the stale-response discard flag
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        if (flow_chg_s) begin
            pc_d    = flow_pc_s;
            state_d = ST_REQ;
            // An unanswered request leaves one stale response to drop; a
            // response arriving this very cycle is simply ignored instead.
            if (state_q == ST_WAIT) begin
                discard_d = ~imem.imem_ready;
            end else begin
                discard_d = discard_q;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (addr_ok_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_ready) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_REQ;
                        end else begin
                            state_d   = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (IR_en) begin
                        pc_d    = pc_plus4_s;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // Output logic: memory request and the IF/ID-facing registered outputs
    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        pc_f_d  = pc_f_q;
        instr_d = instr_q;
        valid_d = valid_q;
        npc_d   = npc_q;
        adel_d  = adel_q;
        if (flow_chg_s) begin
            req_d   = 1'b0;
            instr_d = 32'h0000_0000;
            valid_d = 1'b0;
            npc_d   = NPC_SEQ;
            adel_d  = 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (addr_ok_s) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end else begin
                        // Bad fetch address: present AdEL without touching memory
                        req_d   = 1'b0;
                        pc_f_d  = pc_q;
                        instr_d = 32'h0000_0000;
                        valid_d = 1'b1;
                        npc_d   = NPC_SEQ;
                        adel_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_ready) begin
                        req_d = 1'b0;
                        if (!discard_q) begin
                            pc_f_d  = pc_q;
                            instr_d = imem.imem_rdata;
                            valid_d = 1'b1;
                            npc_d   = pre_npc_s;
                            adel_d  = 1'b0;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end else begin
                        req_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (IR_en) begin
                        instr_d = 32'h0000_0000;
                        valid_d = 1'b0;
                        npc_d   = NPC_SEQ;
                        adel_d  = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign PC_F           = pc_f_q;
    assign instr_F        = instr_q;
    assign instr_valid_F  = valid_q;
    assign nPC_sel_F      = npc_q;
    assign exc_adel_F     = adel_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        IR_en;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] EPC;
    logic [31:0] PC_F;
    logic [31:0] instr_F;
    logic        instr_valid_F;
    logic [2:0]  nPC_sel_F;
    logic        exc_adel_F;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_stage_if imem_bus ();

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .IR_en         (IR_en),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .EPC           (EPC),
        .imem          (imem_bus),
        .PC_F          (PC_F),
        .instr_F       (instr_F),
        .instr_valid_F (instr_valid_F),
        .nPC_sel_F     (nPC_sel_F),
        .exc_adel_F    (exc_adel_F)
    );

    always #5 clk = ~clk;

    // Entered during a REQ cycle; walks WAIT (ready at once), HOLD (+stall), back to REQ
    task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] word,
                             input logic [2:0] exp_npc, input int stall);
        @(negedge clk);
        n_cmp++;
        if ({imem_bus.imem_req, imem_bus.imem_addr, instr_valid_F} !== {1'b1, exp_pc, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_req: got req=%0b addr=%h valid=%0b, want req=1 addr=%h valid=0",
                     imem_bus.imem_req, imem_bus.imem_addr, instr_valid_F, exp_pc);
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clk);
        n_cmp++;
        if ({instr_valid_F, exc_adel_F, PC_F, instr_F, nPC_sel_F, imem_bus.imem_req} !==
            {1'b1, 1'b0, exp_pc, word, exp_npc, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_present: got v=%0b adel=%0b pc=%h ins=%h npc=%0d req=%0b, want v=1 adel=0 pc=%h ins=%h npc=%0d req=0",
                     instr_valid_F, exc_adel_F, PC_F, instr_F, nPC_sel_F, imem_bus.imem_req,
                     exp_pc, word, exp_npc);
        end
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0000_0000;
        IR_en = (stall == 0) ? 1'b1 : 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({instr_valid_F, PC_F, instr_F, imem_bus.imem_req} !== {1'b1, exp_pc, word, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%0b pc=%h ins=%h req=%0b, want v=1 pc=%h ins=%h req=0",
                         i, instr_valid_F, PC_F, instr_F, imem_bus.imem_req, exp_pc, word);
            end
            if (i == stall - 1) IR_en = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        if ({instr_valid_F, instr_F, imem_bus.imem_req} !== {1'b0, 32'h0000_0000, 1'b0}) begin
            n_err++;
            $display("FAIL handoff: got v=%0b ins=%h req=%0b, want v=0 ins=0 req=0",
                     instr_valid_F, instr_F, imem_bus.imem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; IR_en = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        exc_req = 1'b0; eret_req = 1'b0; EPC = 32'h0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({PC_F, instr_F, instr_valid_F, nPC_sel_F, exc_adel_F, imem_bus.imem_req} !==
            {32'h0000_3000, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got pc=%h ins=%h v=%0b npc=%0d adel=%0b req=%0b, want pc=00003000 rest 0",
                     PC_F, instr_F, instr_valid_F, nPC_sel_F, exc_adel_F, imem_bus.imem_req);
        end
        reset = 1'b1;
        IR_en = 1'b1;
    endtask

    task automatic test_sequential();
        fetch_one(32'h0000_3000, 32'h0C00_0C00, 3'd2, 0);   // jal
    endtask

    task automatic test_stall();
        fetch_one(32'h0000_3004, 32'h1000_0003, 3'd1, 4);   // beq, stalled 4 cycles
        fetch_one(32'h0000_3008, 32'h0000_0008, 3'd3, 0);   // jr
    endtask

    task automatic test_predecode();
        fetch_one(32'h0000_300C, 32'h4200_0018, 3'd4, 0);   // eret
        fetch_one(32'h0000_3010, 32'h0401_0002, 3'd1, 0);   // regimm
        fetch_one(32'h0000_3014, 32'h0800_0C00, 3'd2, 0);   // j
        fetch_one(32'h0000_3018, 32'h0000_F809, 3'd3, 0);   // jalr
        fetch_one(32'h0000_301C, 32'h0000_0020, 3'd0, 0);   // add
    endtask

    task automatic test_redirect_wait();
        @(negedge clk);
        n_cmp++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0000_3020}) begin
            n_err++;
            $display("FAIL redir_pre: got req=%0b addr=%h, want req=1 addr=00003020",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        redirect_en = 1'b1; redirect_pc = 32'h0000_3100;
        @(negedge clk);
        redirect_en = 1'b0;
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F} !== 2'b00) begin
            n_err++;
            $display("FAIL redir_req_drop: got req=%0b v=%0b, want 0 0", imem_bus.imem_req, instr_valid_F);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({imem_bus.imem_req, imem_bus.imem_addr, instr_valid_F} !== {1'b1, 32'h0000_3100, 1'b0}) begin
                n_err++;
                $display("FAIL redir_newaddr[%0d]: got req=%0b addr=%h v=%0b, want req=1 addr=00003100 v=0",
                         i, imem_bus.imem_req, imem_bus.imem_addr, instr_valid_F);
            end
        end
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F, instr_F} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL redir_discard: got req=%0b v=%0b ins=%h, want 0 0 00000000",
                     imem_bus.imem_req, instr_valid_F, instr_F);
        end
        fetch_one(32'h0000_3100, 32'h0000_0020, 3'd0, 0);
    endtask

    task automatic test_exc_eret();
        @(negedge clk);
        n_cmp++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0000_3104}) begin
            n_err++;
            $display("FAIL exc_pre: got req=%0b addr=%h, want req=1 addr=00003104",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        exc_req = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h0000_3200;
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h0C00_0C00;
        @(negedge clk);
        exc_req = 1'b0; redirect_en = 1'b0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F} !== 2'b00) begin
            n_err++;
            $display("FAIL exc_same_ready: got req=%0b v=%0b, want 0 0", imem_bus.imem_req, instr_valid_F);
        end
        fetch_one(32'h0000_4180, 32'h0000_0020, 3'd0, 0);
        eret_req = 1'b1; EPC = 32'h0000_3010;
        @(negedge clk);
        eret_req = 1'b0;
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F} !== 2'b00) begin
            n_err++;
            $display("FAIL eret_req_drop: got req=%0b v=%0b, want 0 0", imem_bus.imem_req, instr_valid_F);
        end
        fetch_one(32'h0000_3010, 32'h4200_0018, 3'd4, 0);
    endtask

    task automatic test_adel();
        IR_en = 1'b0;
        redirect_en = 1'b1; redirect_pc = 32'h0000_3002;
        @(negedge clk);
        redirect_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F, exc_adel_F, instr_F, PC_F, nPC_sel_F} !==
            {1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_3002, 3'd0}) begin
            n_err++;
            $display("FAIL adel_misalign: got req=%0b v=%0b adel=%0b ins=%h pc=%h npc=%0d, want 0 1 1 0 00003002 0",
                     imem_bus.imem_req, instr_valid_F, exc_adel_F, instr_F, PC_F, nPC_sel_F);
        end
        redirect_en = 1'b1; redirect_pc = 32'h0000_5000;
        @(negedge clk);
        redirect_en = 1'b0;
        n_cmp++;
        if ({instr_valid_F, exc_adel_F} !== 2'b00) begin
            n_err++;
            $display("FAIL adel_clear: got v=%0b adel=%0b, want 0 0", instr_valid_F, exc_adel_F);
        end
        @(negedge clk);
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F, exc_adel_F, instr_F, PC_F, nPC_sel_F} !==
            {1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_5000, 3'd0}) begin
            n_err++;
            $display("FAIL adel_range: got req=%0b v=%0b adel=%0b ins=%h pc=%h npc=%0d, want 0 1 1 0 00005000 0",
                     imem_bus.imem_req, instr_valid_F, exc_adel_F, instr_F, PC_F, nPC_sel_F);
        end
        redirect_en = 1'b1; redirect_pc = 32'h0000_4FFC;
        @(negedge clk);
        redirect_en = 1'b0;
        IR_en = 1'b1;
        fetch_one(32'h0000_4FFC, 32'h0800_0C00, 3'd2, 0);   // highest legal address
    endtask

    task automatic test_reset_wait();
        redirect_en = 1'b1; redirect_pc = 32'h0000_3040;
        @(negedge clk);
        redirect_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0000_3040}) begin
            n_err++;
            $display("FAIL rstwait_pre: got req=%0b addr=%h, want req=1 addr=00003040",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({imem_bus.imem_req, instr_valid_F, PC_F, instr_F, nPC_sel_F, exc_adel_F} !==
            {1'b0, 1'b0, 32'h0000_3000, 32'h0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rstwait_async: got req=%0b v=%0b pc=%h ins=%h npc=%0d adel=%0b, want 0 0 00003000 0 0 0",
                     imem_bus.imem_req, instr_valid_F, PC_F, instr_F, nPC_sel_F, exc_adel_F);
        end
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        reset = 1'b1;
        fetch_one(32'h0000_3000, 32'h1400_FFFF, 3'd1, 0);   // bne
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_predecode();
        test_redirect_wait();
        test_exc_eret();
        test_adel();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
